// File: rtl/switch_conditioner_pkg.sv
// switch_conditioner_pkg
//   Shared constants for the slide-switch input stage.
//   SW_SYNC_STAGES     : synchroniser depth used by the board build.
//   SW_DEBOUNCE_CYCLES : debounce window in Clock cycles. The board build
//                        (`demo) uses 10 ms at 50 MHz; simulation builds use a
//                        short window so benches finish quickly.
package switch_conditioner_pkg;

    localparam int SW_SYNC_STAGES = 2;

`ifdef demo
    localparam int SW_DEBOUNCE_CYCLES = 500000;
`else
    localparam int SW_DEBOUNCE_CYCLES = 4;
`endif

endpackage

// File: rtl/switch_conditioner_debounce_bit.sv
// debounce_bit
//   One-bit synchroniser, debounce counter, stable register and edge strobes.
//   Ports:
//     Clock  in  : system clock, all state on the rising edge
//     Reset  in  : asynchronous active-low reset, clears every flop
//     raw    in  : unsynchronised switch pin
//     level  out : debounced level
//     rise   out : one-cycle strobe when level goes 0->1
//     fall   out : one-cycle strobe when level goes 1->0
module debounce_bit #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int              CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic IDLE  = 1'b0;
    localparam logic COUNT = 1'b1;

    generate
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $fatal(1, "debounce_bit: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
            $fatal(1, "debounce_bit: DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic                   state;

    // Synchroniser stage: only the last flop of the chain is ever consumed.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_p[SYNC_STAGES-1];

    // The state is fully implied by whether the sampled level disagrees with
    // the accepted one; the counter carries how long it has disagreed.
    assign state = (s != level) ? COUNT : IDLE;

    // Debounce stage: the counter saturates at LAST and acceptance resets it,
    // so it can never wrap.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (state == IDLE) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                level <= s;
                cnt   <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// switch_conditioner
//   Input stage between the board slide switches and cpu.Switches. Every
//   switch is synchronised and debounced independently, so the handshake
//   switch (bit 8) never shows metastable or bouncing levels to control.
//   Ports:
//     Clock       in        : system clock
//     Reset       in        : asynchronous active-low reset
//     RawSwitches in  [N]   : unsynchronised switch pins
//     Switches    out [N]   : debounced levels, feeds cpu.Switches
//     Rise        out [N]   : one-cycle 0->1 strobe per bit
//     Fall        out [N]   : one-cycle 1->0 strobe per bit
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int N               = 10,
    parameter int SYNC_STAGES     = SW_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] RawSwitches,
    output logic [N-1:0] Switches,
    output logic [N-1:0] Rise,
    output logic [N-1:0] Fall
);

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            debounce_bit #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_bit (
                .Clock (Clock),
                .Reset (Reset),
                .raw   (RawSwitches[i]),
                .level (Switches[i]),
                .rise  (Rise[i]),
                .fall  (Fall[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_switch_conditioner.sv
module tb_switch_conditioner;

    localparam int N    = 10;
    localparam int SYNC = 2;
    localparam int D    = 4;

    logic         Clock;
    logic         Reset;
    logic [N-1:0] RawSwitches;
    logic [N-1:0] Switches;
    logic [N-1:0] Rise;
    logic [N-1:0] Fall;

    int errors = 0;
    int checks = 0;

    switch_conditioner #(
        .N               (N),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .RawSwitches (RawSwitches),
        .Switches    (Switches),
        .Rise        (Rise),
        .Fall        (Fall)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model: a switch level is accepted when the synchronised
    // samples of the last D edges all differ from the current level.
    logic [N-1:0] samp[$];
    logic [N-1:0] exp_sw, exp_rise, exp_fall;

    task automatic model_reset();
        samp.delete();
        for (int k = 0; k < SYNC; k++) samp.push_back('0);
        exp_sw   = '0;
        exp_rise = '0;
        exp_fall = '0;
    endtask

    task automatic model_edge();
        int  last;
        bit  ok;
        logic v;
        if (!Reset) begin
            model_reset();
            return;
        end
        samp.push_back(RawSwitches);
        if (samp.size() > SYNC + D + 2) void'(samp.pop_front());
        exp_rise = '0;
        exp_fall = '0;
        last = samp.size() - 1 - SYNC;
        for (int b = 0; b < N; b++) begin
            v  = ~exp_sw[b];
            ok = (last - (D - 1)) >= 0;
            if (ok) begin
                for (int j = 0; j < D; j++)
                    if (samp[last - j][b] !== v) ok = 0;
            end
            if (ok) begin
                exp_sw[b]   = v;
                exp_rise[b] = v;
                exp_fall[b] = ~v;
            end
        end
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        model_edge();
        #1;
        check("sw",   Switches, exp_sw);
        check("rise", Rise,     exp_rise);
        check("fall", Fall,     exp_fall);
    endtask

    task automatic settle(input int n);
        repeat (n) tick();
    endtask

    int   cnt_r;
    logic acc;
    int   hold;

    initial begin
        // 1: reset with all switches high
        Reset       = 1'b0;
        RawSwitches = 10'h3FF;
        model_reset();
        #3;
        check("rst_sw",   Switches, '0);
        check("rst_rise", Rise,     '0);
        check("rst_fall", Fall,     '0);
        settle(3);
        tick();
        Reset = 1'b1;                               // edge 0
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (e == 5) check("t1_sw_e5", Switches, '0);
            if (e == 6) begin
                check("t1_sw_e6",   Switches, 10'h3FF);
                check("t1_rise_e6", Rise,     10'h3FF);
            end
            if (e == 7) check("t1_rise_e7", Rise, '0);
        end

        // 2: clean press and release of bit 8
        RawSwitches = '0;
        settle(10);
        tick();
        RawSwitches[8] = 1'b1;                      // edge 0
        for (int e = 1; e <= 27; e++) begin
            tick();
            if (e == 5)  check("t2_sw8_e5",  {9'b0, Switches[8]}, 10'h000);
            if (e == 6) begin
                check("t2_sw8_e6",   {9'b0, Switches[8]}, 10'h001);
                check("t2_rise8_e6", {9'b0, Rise[8]},     10'h001);
            end
            if (e == 20) RawSwitches[8] = 1'b0;
            if (e == 26) begin
                check("t2_sw8_e26",   {9'b0, Switches[8]}, 10'h000);
                check("t2_fall8_e26", {9'b0, Fall[8]},     10'h001);
            end
            if (e == 27) check("t2_fall8_e27", {9'b0, Fall[8]}, 10'h000);
        end

        // 3: bounce on bit 3
        settle(4);
        tick();
        RawSwitches[3] = 1'b1;                      // edge 0
        cnt_r = 0;
        for (int e = 1; e <= 14; e++) begin
            tick();
            if (Rise[3]) cnt_r++;
            if (e == 3) RawSwitches[3] = 1'b0;
            if (e == 4) RawSwitches[3] = 1'b1;      // final rising sample at edge 5, set at edge 4
            if (e == 9)  check("t3_sw3_e9",    {9'b0, Switches[3]}, 10'h000);
            if (e == 10) check("t3_rise3_e10", {9'b0, Rise[3]},     10'h001);
        end
        check("t3_rise3_count", N'(cnt_r), N'(1));

        // 4: 3-cycle glitch on bit 0
        tick();
        RawSwitches[0] = 1'b1;
        acc = 1'b0;
        for (int e = 1; e <= 13; e++) begin
            tick();
            acc = acc | Switches[0] | Rise[0] | Fall[0];
            if (e == 3) RawSwitches[0] = 1'b0;
        end
        check("t4_glitch0", {9'b0, acc}, 10'h000);

        // 5: reset in the middle of a count on bit 5
        tick();
        RawSwitches[5] = 1'b1;                      // edge 0
        cnt_r = 0;
        for (int e = 1; e <= 4; e++) begin
            tick();
            if (Rise[5]) cnt_r++;
        end
        #2;
        Reset = 1'b0;
        model_reset();
        #1;
        check("t5_rst_sw",   Switches, '0);
        check("t5_rst_rise", Rise,     '0);
        check("t5_rst_fall", Fall,     '0);
        check("t5_rst_cnt5", N'(dut.g_bit[5].u_bit.cnt), '0);
        tick();
        Reset = 1'b1;                               // release at edge 0
        for (int e = 1; e <= 8; e++) begin
            tick();
            if (Rise[5]) cnt_r++;
            if (e == 5) check("t5_rise5_e5", {9'b0, Rise[5]}, 10'h000);
            if (e == 6) check("t5_rise5_e6", {9'b0, Rise[5]}, 10'h001);
        end
        check("t5_rise5_count", N'(cnt_r), N'(1));

        // 6: simultaneous rise on bit 1 and fall on bit 2
        RawSwitches = 10'h004;
        settle(12);
        tick();
        RawSwitches = 10'h002;                      // edge 0
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 6) begin
                check("t6_rise_e6", Rise, 10'h002);
                check("t6_fall_e6", Fall, 10'h004);
                check("t6_sw_e6",   Switches, 10'h002);
            end
        end

        // Random phase with one asynchronous reset in the middle
        hold = 0;
        for (int it = 0; it < 500; it++) begin
            if (it == 250) begin
                #2;
                Reset = 1'b0;
                model_reset();
                #1;
                check("rnd_rst_sw", Switches, '0);
                tick();
                Reset = 1'b1;
            end
            if (hold == 0) begin
                RawSwitches = RawSwitches ^ (N'($urandom) & N'($urandom));
                hold = $urandom_range(1, 7);
            end
            hold--;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
